custom_fifo_uart_tx: RTL

//   Parallel-to-serial byte buffer feeding the UART transmitter. Accepts one

---
 rtl/custom_fifo_uart_tx.sv | 79 +++++++
 1 files changed

// File: rtl/custom_fifo_uart_tx.sv
// Block-to-word serializer in front of the UART transmitter.
// Latches one DEPTH-word block and streams it out word 0 first.
module custom_fifo_uart_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   valid_i,
    input  logic [DEPTH*WIDTH-1:0] write_data,
    output logic                   ready_o,
    output logic [WIDTH-1:0]       tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]                  state;
    logic [IW-1:0]               idx;
    logic [GW-1:0]               gap_cnt;
    logic [DEPTH-1:0][WIDTH-1:0] blk;
    logic                        last;

    assign ready_o  = (state == ST_IDLE);
    assign tx_valid = (state == ST_SEND);
    assign tx_data  = blk[idx];
    assign last     = (idx == IW'(DEPTH - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state   <= ST_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            blk     <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (1'b1)
                state == ST_IDLE: begin
                    if (valid_i) begin
                        blk   <= write_data;
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                state == ST_SEND: begin
                    if (tx_ready) begin
                        if (last) begin
                            idx    <= '0;
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                            // no spacing after the final word
                            if (GAP > 0) begin
                                gap_cnt <= GW'(GAP);
                                state   <= ST_GAP;
                            end
                        end
                    end
                end
                state == ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GW'(1)) state <= ST_SEND;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
